wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
- Three-master, one-slave Wishbone arbiter with round-robin grant and a per-transfer watchdog.
- Shares one slave port (DDR/SRAM controller or a sensor-node bridge) between the LM32 instruction bus, the LM32 data bus and a future DMA/sensor-poller master.
- Placed between the masters and a conbus slave port. It can also stand alone in front of one slave.
- Ownership is held for the whole CYC. A transfer that hangs without ACK is terminated with ERR to the owning master.

Parameters:
- adr_width, 32, address width of the master and slave ports.
- timeout, 255, cycles the owner may hold STB without ACK/ERR before the watchdog fires. Legal range 2..65535.
- cnt_width, 16, width of the watchdog counter. Must satisfy timeout < 2**cnt_width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- mN_adr_i  in  adr_width  master N address (N = 0,1,2 for all mN_ ports).
- mN_dat_i  in  32  master N write data.
- mN_dat_o  out  32  read data, broadcast from s_dat_i to all masters.
- mN_sel_i  in  4  byte select.
- mN_we_i  in  1  write enable.
- mN_cyc_i  in  1  cycle request.
- mN_stb_i  in  1  strobe.
- mN_ack_o  out  1  acknowledge, gated to the owner.
- mN_err_o  out  1  error (slave error or watchdog), gated to the owner.
- s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o  out  adr_width/32/4/1/1/1  slave-side request, muxed from the owner.
- s_dat_i  in  32  slave read data.
- s_ack_i  in  1  slave acknowledge.
- s_err_i  in  1  slave error. Tie to 0 if the slave has none.
- grant_o  out  3  one-hot current owner. 000 when idle.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (async, while reset=1):
  - state=IDLE, grant_o=000, last=2 (master 0 has top priority after reset).
  - Watchdog counter=0, timeout_o=0.
  - All mN_ack_o/mN_err_o=0, s_cyc_o=s_stb_o=s_we_o=0.
  - s_adr_o/s_dat_o/s_sel_o=0 while idle.
- State IDLE:
  - On a rising edge with any mN_cyc_i=1, the arbiter picks the first requester in order last+1, last+2, last+3 (mod 3).
  - It then registers grant_o and moves to BUSY. Arbitration latency is 1 cycle from CYC seen to s_cyc_o asserted.
- State BUSY:
  - s_* outputs are combinationally driven from the owner's inputs.
  - s_cyc_o = owner cyc, except when forced to 0 as described for the watchdog below.
  - s_stb_o = owner stb, with the same exception.
  - mN_ack_o = s_ack_i & grant_o[N]. mN_err_o = (s_err_i | wd_fire) & grant_o[N].
  - Non-owners always see ack=err=0. Their requests are ignored and held pending.
- Release:
  - When the owner samples cyc=0 on a rising edge: last := owner, grant_o := 000, state := IDLE.
  - Exactly one idle cycle always separates two grants, even when other masters are waiting.
  - Ownership is never pre-empted while the owner holds CYC. Back-to-back STBs within one CYC, including LM32 bursts, stay with the owner.
- Watchdog:
  - The counter clears to 0 on any cycle with s_ack_i|s_err_i, with owner stb=0, or in IDLE.
  - Otherwise it increments.
  - wd_fire=1 combinationally when counter == timeout-1 and owner stb=1 and s_ack_i=0. This is the timeout-th consecutive wait cycle.
  - On wd_fire:
    - owner err_o=1 for that cycle; s_cyc_o/s_stb_o are forced 0 that cycle; timeout_o is a registered pulse on the next cycle.
    - The counter clears. Ownership is retained until the master drops CYC.
  - If s_ack_i arrives in the same cycle the watchdog would fire, the ACK wins: no error and no timeout_o.
- Simultaneous events:
  - A request arriving in the same cycle as a release is seen in IDLE on the next edge.
  - A slave ACK while the owner stb=0 is ignored and not forwarded.
- Reset asserted mid-transfer drops s_cyc_o immediately (async). No ACK is delivered for the interrupted transfer.
- All mux and priority logic is combinational from registered grant_o. There is no combinational path from mN_cyc_i to grant_o.

Test Plan:
- Single master: m1 issues a read to 0x00000040 and the slave ACKs after 2 wait cycles with 0xDEADBEEF.
  - grant_o=010 one cycle after CYC.
  - m1_ack_o is high on the same cycle as s_ack_i, with m1_dat_o=0xDEADBEEF.
  - m0_ack_o and m2_ack_o stay 0.
- All three masters assert CYC together right after reset, each doing one write.
  - Grant order is 001, 010, 100.
  - One idle cycle (grant_o=000) between each grant.
- Fairness: m0 holds CYC for 4 back-to-back ACKed STBs while m2 and m1 request.
  - s_cyc_o stays high through all 4.
  - After m0 releases, the next grant is m1 (010), then m2.
- Watchdog with timeout=8: the owner m2 strobes and the slave never ACKs.
  - m2_err_o=1 on the 8th wait cycle, with s_stb_o=0 that cycle.
  - timeout_o pulses on the next cycle.
  - After m2 drops CYC, grant_o=000.
- ACK/timeout race with timeout=8: s_ack_i asserted on the 8th wait cycle.
  - m2_ack_o=1, m2_err_o=0, timeout_o stays 0.
- Reset mid-transfer: assert reset while m1 owns the bus with STB pending.
  - s_cyc_o, s_stb_o and grant_o go to 0 before the next clock edge.
  - After reset deasserts with m0 and m1 both requesting, m0 is granted first.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter
//   Three-master / one-slave Wishbone arbiter. Grants rotate round-robin
//   and ownership lasts for the whole CYC. A per-transfer watchdog ends a
//   strobe that has waited `timeout` cycles with an ERR to the owner.
//
// Ports
//   clk, reset           system clock, asynchronous active-high reset
//   mN_*_i  (N=0..2)     master request: adr, dat, sel, we, cyc, stb
//   mN_dat_o             slave read data, broadcast to every master
//   mN_ack_o, mN_err_o   response, visible only to the current owner
//   s_*_o                request to the slave, muxed from the owner
//   s_dat_i/ack_i/err_i  slave response
//   grant_o              one-hot owner, 000 while idle
//   timeout_o            one-cycle pulse, the cycle after the watchdog fires
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; the next edge picks a requester after last_q
// BUSY  | grant_q owns the slave until it drops CYC
module wb_rr_arbiter #(
  parameter int adr_width = 32,
  parameter int timeout   = 255,
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [adr_width-1:0] m0_adr_i,
  input  logic [31:0]          m0_dat_i,
  output logic [31:0]          m0_dat_o,
  input  logic [3:0]           m0_sel_i,
  input  logic                 m0_we_i,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,
  input  logic [adr_width-1:0] m1_adr_i,
  input  logic [31:0]          m1_dat_i,
  output logic [31:0]          m1_dat_o,
  input  logic [3:0]           m1_sel_i,
  input  logic                 m1_we_i,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,
  input  logic [adr_width-1:0] m2_adr_i,
  input  logic [31:0]          m2_dat_i,
  output logic [31:0]          m2_dat_o,
  input  logic [3:0]           m2_sel_i,
  input  logic                 m2_we_i,
  input  logic                 m2_cyc_i,
  input  logic                 m2_stb_i,
  output logic                 m2_ack_o,
  output logic                 m2_err_o,
  output logic [adr_width-1:0] s_adr_o,
  output logic [31:0]          s_dat_o,
  output logic [3:0]           s_sel_o,
  output logic                 s_we_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  input  logic [31:0]          s_dat_i,
  input  logic                 s_ack_i,
  input  logic                 s_err_i,
  output logic [2:0]           grant_o,
  output logic                 timeout_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [cnt_width-1:0] WD_LAST = cnt_width'(timeout - 1);

  state_t               state_q, state_d;
  logic [2:0]           grant_q, grant_d;
  logic [1:0]           last_q, last_d;
  logic [cnt_width-1:0] wd_cnt_q, wd_cnt_d;
  logic                 timeout_q, timeout_d;

  logic [adr_width-1:0] own_adr;
  logic [31:0]          own_dat;
  logic [3:0]           own_sel;
  logic                 own_we, own_cyc, own_stb;
  logic [1:0]           own_idx;
  logic [2:0]           req;
  logic [2:0]           pick;
  logic                 wd_fire;
  logic                 ack_fwd, err_fwd;

  assign req = {m2_cyc_i, m1_cyc_i, m0_cyc_i};

  // Owner mux; grant_q is 000 when idle so everything reads as zero then.
  always_comb begin
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    own_we  = 1'b0;
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_idx = 2'd0;
    case (grant_q)
      3'b001: begin
        own_adr = m0_adr_i; own_dat = m0_dat_i; own_sel = m0_sel_i;
        own_we  = m0_we_i;  own_cyc = m0_cyc_i; own_stb = m0_stb_i;
        own_idx = 2'd0;
      end
      3'b010: begin
        own_adr = m1_adr_i; own_dat = m1_dat_i; own_sel = m1_sel_i;
        own_we  = m1_we_i;  own_cyc = m1_cyc_i; own_stb = m1_stb_i;
        own_idx = 2'd1;
      end
      3'b100: begin
        own_adr = m2_adr_i; own_dat = m2_dat_i; own_sel = m2_sel_i;
        own_we  = m2_we_i;  own_cyc = m2_cyc_i; own_stb = m2_stb_i;
        own_idx = 2'd2;
      end
      default: ;
    endcase
  end

  // Round-robin pick: search starts at the master after the last owner.
  always_comb begin
    pick = 3'b000;
    case (last_q)
      2'd0: begin
        if      (req[1]) pick = 3'b010;
        else if (req[2]) pick = 3'b100;
        else if (req[0]) pick = 3'b001;
      end
      2'd1: begin
        if      (req[2]) pick = 3'b100;
        else if (req[0]) pick = 3'b001;
        else if (req[1]) pick = 3'b010;
      end
      default: begin
        if      (req[0]) pick = 3'b001;
        else if (req[1]) pick = 3'b010;
        else if (req[2]) pick = 3'b100;
      end
    endcase
  end

  // A same-cycle ACK beats the watchdog.
  assign wd_fire = (state_q == BUSY) & own_cyc & own_stb & ~s_ack_i &
                   (wd_cnt_q == WD_LAST);

  // Responses arriving without an owner strobe are dropped.
  assign ack_fwd = s_ack_i & own_stb;
  assign err_fwd = (s_err_i & own_stb) | wd_fire;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    wd_cnt_d  = '0;
    timeout_d = wd_fire;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          last_d  = own_idx;
          grant_d = 3'b000;
          state_d = IDLE;
        end else if (!(s_ack_i | s_err_i | ~own_stb | wd_fire)) begin
          wd_cnt_d = wd_cnt_q + cnt_width'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= 3'b000;
      last_q    <= 2'd2;
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign s_adr_o = own_adr;
  assign s_dat_o = own_dat;
  assign s_sel_o = own_sel;
  assign s_we_o  = own_we;
  assign s_cyc_o = own_cyc & ~wd_fire;
  assign s_stb_o = own_stb & ~wd_fire;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m2_dat_o = s_dat_i;

  assign m0_ack_o = ack_fwd & grant_q[0];
  assign m1_ack_o = ack_fwd & grant_q[1];
  assign m2_ack_o = ack_fwd & grant_q[2];
  assign m0_err_o = err_fwd & grant_q[0];
  assign m1_err_o = err_fwd & grant_q[1];
  assign m2_err_o = err_fwd & grant_q[2];

  assign grant_o   = grant_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Testbench for wb_rr_arbiter (timeout = 8). Stimulus pushes expected
// grants and responses into queues; two monitors pop and compare them
// whenever the arbiter presents a new grant or an ack/err.
module tb_wb_rr_arbiter;
  localparam int AW = 32;
  localparam int TO = 8;

  typedef struct {
    int          m;
    bit          is_err;
    bit          chk_dat;
    logic [31:0] dat;
  } resp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] m_adr  [3];
  logic [31:0]   m_wdat [3];
  logic [3:0]    m_sel  [3];
  logic          m_we   [3];
  logic          m_cyc  [3];
  logic          m_stb  [3];
  logic [31:0]   m_rdat [3];
  logic          m_ack  [3];
  logic          m_err  [3];
  logic [AW-1:0] s_adr;
  logic [31:0]   s_dat_o;
  logic [3:0]    s_sel;
  logic          s_we, s_cyc, s_stb;
  logic [31:0]   s_dat_i;
  logic          s_ack_i, s_err_i;
  logic [2:0]    grant;
  logic          timeout_o;

  resp_t      resp_q  [$];
  logic [2:0] grant_q [$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.adr_width(AW), .timeout(TO), .cnt_width(16)) dut (
    .clk(clk), .reset(reset),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_wdat[0]), .m0_dat_o(m_rdat[0]), .m0_sel_i(m_sel[0]),
    .m0_we_i(m_we[0]), .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_ack_o(m_ack[0]), .m0_err_o(m_err[0]),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_wdat[1]), .m1_dat_o(m_rdat[1]), .m1_sel_i(m_sel[1]),
    .m1_we_i(m_we[1]), .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_ack_o(m_ack[1]), .m1_err_o(m_err[1]),
    .m2_adr_i(m_adr[2]), .m2_dat_i(m_wdat[2]), .m2_dat_o(m_rdat[2]), .m2_sel_i(m_sel[2]),
    .m2_we_i(m_we[2]), .m2_cyc_i(m_cyc[2]), .m2_stb_i(m_stb[2]), .m2_ack_o(m_ack[2]), .m2_err_o(m_err[2]),
    .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_sel_o(s_sel), .s_we_o(s_we), .s_cyc_o(s_cyc), .s_stb_o(s_stb),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant_o(grant), .timeout_o(timeout_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int n, input logic we, input logic [AW-1:0] adr, input logic [31:0] wdat);
    m_adr[n]  = adr;
    m_wdat[n] = wdat;
    m_sel[n]  = 4'hF;
    m_we[n]   = we;
    m_cyc[n]  = 1'b1;
    m_stb[n]  = 1'b1;
  endtask

  task automatic stop(input int n);
    m_cyc[n] = 1'b0;
    m_stb[n] = 1'b0;
  endtask

  task automatic wait_grant(input int n, output bit ok);
    int k;
    k = 0;
    while (grant[n] !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    ok = (grant[n] === 1'b1);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL grant_wait: master %0d not granted in 20 cycles, grant=%b", n, grant);
    end
  endtask

  // Owner n does `beats` zero-wait STBs, all ACKed, then drops CYC.
  task automatic serve(input int n, input int beats, input logic [31:0] rdat);
    bit ok;
    wait_grant(n, ok);
    if (ok) begin
      for (int b = 0; b < beats; b++) begin
        check("s_cyc_hold", 64'(s_cyc), 64'(1));
        check("s_adr_mux", 64'(s_adr), 64'(m_adr[n]));
        if (m_we[n]) check("s_dat_mux", 64'(s_dat_o), 64'(m_wdat[n]));
        s_ack_i = 1'b1;
        s_dat_i = rdat;
        resp_q.push_back('{n, 1'b0, !m_we[n], rdat});
        tick();
      end
    end
    s_ack_i = 1'b0;
    stop(n);
    tick();
  endtask

  // Response monitor
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      for (int n = 0; n < 3; n++) begin
        if (m_ack[n] === 1'b1 || m_err[n] === 1'b1) begin
          if (resp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp: master %0d ack=%0b err=%0b, expected none at %0t",
                     n, m_ack[n], m_err[n], $time);
          end else begin
            e = resp_q.pop_front();
            check("resp_master", 64'(n), 64'(e.m));
            check("resp_ack", 64'(m_ack[n]), 64'(!e.is_err));
            check("resp_err", 64'(m_err[n]), 64'(e.is_err));
            if (e.chk_dat) check("resp_data", 64'(m_rdat[n]), 64'(e.dat));
          end
        end
      end
    end
  end

  // Grant monitor: order and the mandatory idle cycle between grants
  initial begin
    logic [2:0] prev;
    logic [2:0] eg;
    prev = 3'b000;
    forever begin
      @(negedge clk);
      if (grant !== prev) begin
        if (grant !== 3'b000) begin
          check("grant_idle_gap", 64'(prev), 64'(0));
          if (grant_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_grant: got %b expected none at %0t", grant, $time);
          end else begin
            eg = grant_q.pop_front();
            check("grant_order", 64'(grant), 64'(eg));
          end
        end
        prev = grant;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, checks=%0d", checks);
    $fatal(1, "global timeout");
  end

  initial begin
    bit ok;
    reset   = 1'b1;
    s_dat_i = 32'h0;
    s_ack_i = 1'b0;
    s_err_i = 1'b0;
    for (int n = 0; n < 3; n++) begin
      m_adr[n] = 32'h1000 + 32'(n); m_wdat[n] = 32'hA5A5_0000 + 32'(n);
      m_sel[n] = 4'hF; m_we[n] = 1'b1; m_cyc[n] = 1'b0; m_stb[n] = 1'b0;
    end
    tick();
    // Reset state
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_s_cyc", 64'(s_cyc), 64'(0));
    check("rst_s_stb", 64'(s_stb), 64'(0));
    check("rst_s_we", 64'(s_we), 64'(0));
    check("rst_s_adr", 64'(s_adr), 64'(0));
    check("rst_timeout", 64'(timeout_o), 64'(0));
    tick();
    reset = 1'b0;
    tick();

    // 1: single master read, two wait cycles
    grant_q.push_back(3'b010);
    start(1, 1'b0, 32'h0000_0040, 32'h0);
    tick();
    check("t1_grant", 64'(grant), 64'(3'b010));
    check("t1_s_cyc", 64'(s_cyc), 64'(1));
    check("t1_s_adr", 64'(s_adr), 64'(32'h40));
    check("t1_s_we", 64'(s_we), 64'(0));
    tick();
    tick();
    s_ack_i = 1'b1;
    s_dat_i = 32'hDEAD_BEEF;
    resp_q.push_back('{1, 1'b0, 1'b1, 32'hDEAD_BEEF});
    tick();
    s_ack_i = 1'b0;
    stop(1);
    tick();
    check("t1_release", 64'(grant), 64'(0));

    // 2: all three request together right after reset
    reset = 1'b1;
    grant_q.push_back(3'b001);
    grant_q.push_back(3'b010);
    grant_q.push_back(3'b100);
    start(0, 1'b1, 32'h2000, 32'h1111_0000);
    start(1, 1'b1, 32'h2004, 32'h2222_0000);
    start(2, 1'b1, 32'h2008, 32'h3333_0000);
    tick();
    reset = 1'b0;
    serve(0, 1, 32'h0);
    serve(1, 1, 32'h0);
    serve(2, 1, 32'h0);

    // 3: m0 burst of 4 while m2 and m1 wait
    grant_q.push_back(3'b001);
    grant_q.push_back(3'b010);
    grant_q.push_back(3'b100);
    start(0, 1'b1, 32'h3000, 32'h4444_0000);
    wait_grant(0, ok);
    start(2, 1'b1, 32'h3008, 32'h6666_0000);
    start(1, 1'b1, 32'h3004, 32'h5555_0000);
    serve(0, 4, 32'h0);
    serve(1, 1, 32'h0);
    serve(2, 1, 32'h0);

    // 4: watchdog fires on the 8th wait cycle
    grant_q.push_back(3'b100);
    start(2, 1'b0, 32'h4000, 32'h0);
    wait_grant(2, ok);
    resp_q.push_back('{2, 1'b1, 1'b0, 32'h0});
    for (int i = 1; i < TO; i++) begin
      if (i == TO - 1) check("t4_stb_before_fire", 64'(s_stb), 64'(1));
      tick();
    end
    check("t4_err", 64'(m_err[2]), 64'(1));
    check("t4_s_stb_forced", 64'(s_stb), 64'(0));
    check("t4_s_cyc_forced", 64'(s_cyc), 64'(0));
    check("t4_timeout_early", 64'(timeout_o), 64'(0));
    tick();
    check("t4_timeout_pulse", 64'(timeout_o), 64'(1));
    stop(2);
    tick();
    check("t4_release", 64'(grant), 64'(0));
    check("t4_timeout_end", 64'(timeout_o), 64'(0));

    // 5: ACK on the would-fire cycle wins
    grant_q.push_back(3'b100);
    start(2, 1'b0, 32'h5000, 32'h0);
    wait_grant(2, ok);
    for (int i = 1; i < TO; i++) tick();
    s_ack_i = 1'b1;
    s_dat_i = 32'h0BAD_F00D;
    resp_q.push_back('{2, 1'b0, 1'b1, 32'h0BAD_F00D});
    #1;
    check("t5_s_stb_kept", 64'(s_stb), 64'(1));
    check("t5_no_err", 64'(m_err[2]), 64'(0));
    tick();
    check("t5_no_timeout", 64'(timeout_o), 64'(0));
    s_ack_i = 1'b0;
    stop(2);
    tick();
    check("t5_release", 64'(grant), 64'(0));

    // 6: reset mid-transfer, then m0 wins over m1
    grant_q.push_back(3'b010);
    start(1, 1'b0, 32'h6000, 32'h0);
    wait_grant(1, ok);
    tick();
    reset = 1'b1;
    #1;
    check("t6_s_cyc_async", 64'(s_cyc), 64'(0));
    check("t6_s_stb_async", 64'(s_stb), 64'(0));
    check("t6_grant_async", 64'(grant), 64'(0));
    grant_q.push_back(3'b001);
    grant_q.push_back(3'b010);
    start(0, 1'b1, 32'h6100, 32'h7777_0000);
    tick();
    reset = 1'b0;
    serve(0, 1, 32'h0);
    serve(1, 1, 32'h1234_5678);

    repeat (3) tick();
    check("resp_queue_empty", 64'(resp_q.size()), 64'(0));
    check("grant_queue_empty", 64'(grant_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
